ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_ram_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_responder                                              |
// | Description : Single-port 256 x 8 byte memory behind a MOV/MOC           |
// |               handshake. An access latches its request, waits            |
// |               WAIT_CYCLES cycles, then moves one byte per cycle          |
// |               (1/2/4 beats, big-endian), then holds MOC until MOV drops. |
// | Ports       : clk        - clock, rising edge                            |
// |               clr        - asynchronous active-low reset                 |
// |               MOV        - memory operation valid (held until MOC)       |
// |               R_W        - 1 = read, 0 = write                           |
// |               address    - byte base address                             |
// |               DT         - size: 00 byte, 01 halfword, 1x word           |
// |               SIGN       - sign-extend byte/halfword reads               |
// |               data_in    - right-justified write data                    |
// |               data_out   - registered read data                          |
// |               MOC        - memory operation complete (registered)        |
// |               ALIGN_ERR  - misaligned request flag (registered)          |
// | Options     : define RAM_ALIGN_CHECK_EN to reject misaligned halfword    |
// |               and word requests; otherwise ALIGN_ERR is tied to 0.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ram_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        MOV,
  input  logic        R_W,
  input  logic [7:0]  address,
  input  logic [1:0]  DT,
  input  logic        SIGN,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        MOC,
  output logic        ALIGN_ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    ACK  = 2'd3
  } state_t;

  // Last value of the wait counter before moving on; only meaningful
  // when WAIT_CYCLES is non-zero (WAIT is never entered otherwise).
  localparam logic [3:0] c_wait_last = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_mem [256];
  logic [7:0]  r_addr;     // address of the current beat, wraps at 8 bits
  logic        r_rw;
  logic        r_sign;
  logic [1:0]  r_last;     // index of the final beat (0, 1 or 3)
  logic [1:0]  r_beat;
  logic [3:0]  r_wait;
  logic        r_skip;     // request rejected, go straight to ACK
  logic [31:0] r_wsh;      // write data, left-justified; top byte goes next
  logic [23:0] r_rsh;      // read bytes gathered so far

  logic [1:0]  w_req_last;
  logic [31:0] w_req_wsh;
  logic        w_req_skip;
  logic [31:0] w_assembled;
  logic [31:0] w_rd_result;
  logic        w_mem_we;

  // Request decode, used only on the accepting edge.
  always_comb begin
    w_req_last = 2'd3;
    w_req_wsh  = data_in;
    case (DT)
      2'b00: begin
        w_req_last = 2'd0;
        w_req_wsh  = {data_in[7:0], 24'h0};
      end
      2'b01: begin
        w_req_last = 2'd1;
        w_req_wsh  = {data_in[15:0], 16'h0};
      end
      default: begin
        w_req_last = 2'd3;
        w_req_wsh  = data_in;
      end
    endcase
  end

`ifdef RAM_ALIGN_CHECK_EN
  logic r_align_err;
  assign w_req_skip = ((DT == 2'b01) && address[0]) ||
                      (DT[1] && (address[1:0] != 2'b00));
  assign ALIGN_ERR  = r_align_err;
`else
  assign w_req_skip = 1'b0;
  assign ALIGN_ERR  = 1'b0;
`endif

  // Earlier bytes shift up as each new byte arrives, so the byte at the
  // base address ends up most significant.
  assign w_assembled = {r_rsh, r_mem[r_addr]};

  always_comb begin
    case (r_last)
      2'd0:    w_rd_result = {{24{r_sign & w_assembled[7]}},  w_assembled[7:0]};
      2'd1:    w_rd_result = {{16{r_sign & w_assembled[15]}}, w_assembled[15:0]};
      default: w_rd_result = w_assembled;
    endcase
  end

  // Gated by state, so an asserted clr (which forces IDLE at once) stops
  // any further beats while keeping bytes already written.
  assign w_mem_we = (r_state == XFER) && !r_rw;

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wsh[31:24];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= IDLE;
      MOC      <= 1'b0;
      data_out <= 32'h0;
      r_addr   <= 8'h0;
      r_rw     <= 1'b0;
      r_sign   <= 1'b0;
      r_last   <= 2'd0;
      r_beat   <= 2'd0;
      r_wait   <= 4'd0;
      r_skip   <= 1'b0;
      r_wsh    <= 32'h0;
      r_rsh    <= 24'h0;
`ifdef RAM_ALIGN_CHECK_EN
      r_align_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (MOV) begin
            r_addr <= address;
            r_rw   <= R_W;
            r_sign <= SIGN;
            r_last <= w_req_last;
            r_skip <= w_req_skip;
            r_wsh  <= w_req_wsh;
            r_rsh  <= 24'h0;
            r_beat <= 2'd0;
            r_wait <= 4'd0;
            if (WAIT_CYCLES != 0) begin
              r_state <= WAIT;
            end else if (w_req_skip) begin
              r_state  <= ACK;
              MOC      <= 1'b1;
              data_out <= 32'h0;
`ifdef RAM_ALIGN_CHECK_EN
              r_align_err <= 1'b1;
`endif
            end else begin
              r_state <= XFER;
            end
          end
        end

        WAIT: begin
          if (r_wait == c_wait_last) begin
            r_wait <= 4'd0;
            if (r_skip) begin
              r_state  <= ACK;
              MOC      <= 1'b1;
              data_out <= 32'h0;
`ifdef RAM_ALIGN_CHECK_EN
              r_align_err <= 1'b1;
`endif
            end else begin
              r_state <= XFER;
            end
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end

        XFER: begin
          r_addr <= r_addr + 8'd1;
          r_wsh  <= r_wsh << 8;
          r_rsh  <= w_assembled[23:0];
          if (r_beat == r_last) begin
            r_beat  <= 2'd0;
            r_state <= ACK;
            MOC     <= 1'b1;
            if (r_rw) begin
              data_out <= w_rd_result;
            end
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end

        ACK: begin
          // Stay complete while the initiator still asserts MOV.
          if (!MOV) begin
            r_state <= IDLE;
            MOC     <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
          end
        end

        default: begin
          r_state <= IDLE;
          MOC     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ram_responder                                           |
// | Description : Randomised scoreboard bench for ram_responder. A driver    |
// |               issues requests and queues the expected completion; a      |
// |               monitor pops and compares on every rising MOC.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ram_responder;

  localparam int W = 2;

  logic        clk;
  logic        clr;
  logic        MOV;
  logic        R_W;
  logic [7:0]  address;
  logic [1:0]  DT;
  logic        SIGN;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MOC;
  logic        ALIGN_ERR;

  ram_responder #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .MOV       (MOV),
    .R_W       (R_W),
    .address   (address),
    .DT        (DT),
    .SIGN      (SIGN),
    .data_in   (data_in),
    .data_out  (data_out),
    .MOC       (MOC),
    .ALIGN_ERR (ALIGN_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        aerr;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem [256];
  logic [31:0] exp_dout;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: byte array, big-endian, plain arithmetic.
  task automatic model(input bit rw, input logic [7:0] a, input logic [1:0] dt,
                       input bit sg, input logic [31:0] wd,
                       output int lat, output logic [31:0] d, output logic ae);
    int     nb;
    bit     mis;
    longint v;
    nb  = (dt == 2'b00) ? 1 : (dt == 2'b01) ? 2 : 4;
    mis = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
    mis = (nb == 2 && (a % 2) != 0) || (nb == 4 && (a % 4) != 0);
`endif
    ae = mis;
    if (mis) begin
      lat = W; d = 32'h0; exp_dout = 32'h0;
      return;
    end
    lat = W + nb;
    if (rw) begin
      v = 0;
      for (int k = 0; k < nb; k++) v = v * 256 + longint'(mem[(int'(a) + k) % 256]);
      if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      d = v[31:0];
      exp_dout = d;
    end else begin
      for (int k = 0; k < nb; k++) mem[(int'(a) + k) % 256] = 8'((wd >> (8 * (nb - 1 - k))) & 32'hFF);
      d = exp_dout;
    end
  endtask

  // Monitor: compare on every rising MOC.
  logic moc_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (clr && MOC === 1'b1 && !moc_q) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_moc: got MOC rise at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("latency",   32'(cyc), 32'(e.cyc));
        chk("data_out",  data_out, e.data);
        chk("align_err", 32'(ALIGN_ERR), 32'(e.aerr));
      end
    end
    moc_q = MOC;
  end

  task automatic do_txn(input bit rw, input logic [7:0] a, input logic [1:0] dt,
                        input bit sg, input logic [31:0] wd, input int hold, input bit early);
    int          lat;
    int          t;
    logic [31:0] d;
    logic        ae;
    exp_t        e;
    @(negedge clk);
    MOV = 1'b1; R_W = rw; address = a; DT = dt; SIGN = sg; data_in = wd;
    @(posedge clk); #1;
    model(rw, a, dt, sg, wd, lat, d, ae);
    e.cyc = cyc + lat; e.data = d; e.aerr = ae;
    exp_q.push_back(e);
    // Inputs after acceptance must be ignored.
    R_W = 1'($urandom); address = 8'($urandom); DT = 2'($urandom);
    SIGN = 1'($urandom); data_in = $urandom;
    if (early) MOV = 1'b0;
    t = 0;
    @(negedge clk);
    while (MOC !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (MOC !== 1'b1) begin
      n_checks++;
      $display("FAIL moc_timeout: got MOC=%b expected 1 within 40 cycles", MOC);
      MOV = 1'b0;
      return;
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("moc_hold", 32'(MOC), 32'd1);
      end
      MOV = 1'b0;
    end
    @(negedge clk);
    chk("moc_clear",   32'(MOC), 32'd0);
    chk("align_clear", 32'(ALIGN_ERR), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; MOV = 1'b0; R_W = 1'b0; address = 8'h0; DT = 2'b00;
    SIGN = 1'b0; data_in = 32'h0; exp_dout = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_moc",   32'(MOC), 32'd0);
    chk("rst_dout",  data_out, 32'h0);
    chk("rst_align", 32'(ALIGN_ERR), 32'd0);
    clr = 1'b1;

    // Fill the whole array so every later read has a known value.
    for (int i = 0; i < 64; i++) do_txn(1'b0, 8'(i * 4), 2'b10, 1'b0, $urandom, 0, 1'b0);

    // Word write / read at 0x10.
    do_txn(1'b0, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, 1'b0);
    do_txn(1'b1, 8'h10, 2'b10, 1'b0, 32'h0, 0, 1'b0);
    chk("word_read_const", data_out, 32'hDEADBEEF);
    do_txn(1'b1, 8'h11, 2'b00, 1'b0, 32'h0, 0, 1'b0);
    chk("byte11_const", data_out, 32'h000000AD);

    // Byte reads with and without sign extension.
    do_txn(1'b1, 8'h13, 2'b00, 1'b1, 32'h0, 0, 1'b0);
    chk("byte_sext_const", data_out, 32'hFFFFFFEF);
    do_txn(1'b1, 8'h13, 2'b00, 1'b0, 32'h0, 0, 1'b0);
    chk("byte_zext_const", data_out, 32'h000000EF);

    // Odd halfword read.
    do_txn(1'b1, 8'h11, 2'b01, 1'b1, 32'h0, 0, 1'b0);
`ifdef RAM_ALIGN_CHECK_EN
    chk("half_misalign_const", data_out, 32'h0);
`else
    chk("half_odd_const", data_out, 32'hFFFFADBE);

    // Word write across the top of the address space.
    do_txn(1'b0, 8'hFE, 2'b10, 1'b0, 32'h11223344, 0, 1'b0);
    do_txn(1'b1, 8'hFE, 2'b00, 1'b0, 32'h0, 0, 1'b0);
    chk("wrap_fe", data_out, 32'h11);
    do_txn(1'b1, 8'hFF, 2'b00, 1'b0, 32'h0, 0, 1'b0);
    chk("wrap_ff", data_out, 32'h22);
    do_txn(1'b1, 8'h00, 2'b00, 1'b0, 32'h0, 0, 1'b0);
    chk("wrap_00", data_out, 32'h33);
    do_txn(1'b1, 8'h01, 2'b00, 1'b0, 32'h0, 0, 1'b0);
    chk("wrap_01", data_out, 32'h44);
`endif

    // Reset during the second beat of a word write.
    @(negedge clk);
    MOV = 1'b1; R_W = 1'b0; address = 8'h40; DT = 2'b10; SIGN = 1'b0; data_in = 32'hA1B2C3D4;
    @(posedge clk);
    #1 MOV = 1'b0;
    repeat (W + 1) @(posedge clk);
    #1 clr = 1'b0;
    #1;
    chk("midrst_moc",   32'(MOC), 32'd0);
    chk("midrst_dout",  data_out, 32'h0);
    chk("midrst_align", 32'(ALIGN_ERR), 32'd0);
    mem[8'h40] = 8'hA1;
    exp_dout = 32'h0;
    #1 clr = 1'b1;
    do_txn(1'b1, 8'h40, 2'b10, 1'b0, 32'h0, 0, 1'b0);

    // MOV held after completion, then early-dropped MOV.
    do_txn(1'b1, 8'h10, 2'b01, 1'b0, 32'h0, 5, 1'b0);
    do_txn(1'b0, 8'h20, 2'b10, 1'b0, 32'hCAFEF00D, 0, 1'b1);
    do_txn(1'b1, 8'h20, 2'b10, 1'b0, 32'h0, 0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      do_txn(1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), $urandom,
             int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
